fifo_bank: RTL
==============

# fifo_bank

Four-channel 12-bit FIFO bank: the storage end of the arbiter interface. It accepts one-hot `push` writes on a shared data bus. It serves one-hot `pop` requests from the arbiter and returns the popped word on `fifo_out`. It also reports per-channel `empty` and `almost_full` status. One instance sits on each side of the arbiter: the input bank that the arbiter pops, and the output bank that it pushes.

## Interface
- `DEPTH`, 8: words per channel; must be a power of 2, at least 4.
- `AF_THRESH`, 6: `almost_full[i]` asserts when `count[i] >= AF_THRESH`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  reset is asynchronous and active-low.
- `push`  in  4  one-hot write strobe; bit i writes `data_in` into channel i.
- `data_in`  in  12  write word.
- `pop`  in  4  one-hot read strobe; bit i pops channel i.
- `fifo_out`  out  12  registered popped word.
- `valid_out`  out  1  `fifo_out` holds a word popped in the previous cycle.
- `empty`  out  4  channel i holds 0 words.
- `almost_full`  out  4  channel i count has reached `AF_THRESH`.
- `full`  out  4  channel i count equals `DEPTH`.
- `error`  out  4  sticky per-channel fault flags; present only with `FIFO_BANK_ERR_EN`.

## Operation
- Each channel has a circular buffer plus `wr_ptr`, `rd_ptr` and `count`.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
  - `count` is `$clog2(DEPTH+1)` bits.
- Push to channel i is accepted when `push[i]` is set and either:
  - the channel is not full, or
  - the same channel is also popped in that cycle.
- Pop from channel i is accepted when `pop[i]` is set and the channel is not empty. There is no bypass: popping an empty channel is ignored even if it is pushed in the same cycle.
- Count update per channel:
  - push and pop together: count unchanged, both pointers advance.
  - push only: count +1.
  - pop only: count −1.
- Multi-hot `push` or `pop`: only the lowest set bit is served and the other bits are ignored.
- Output register:
  - On an accepted pop, `fifo_out` loads the head word and `valid_out` is 1 in the following cycle.
  - Otherwise `valid_out` is 0 and `fifo_out` holds its last value.
- Status outputs are combinational from `count`.
- Reset values:
  - `empty` = 4'b1111.
  - `almost_full`, `full` and `error` = 0.
  - `fifo_out` = 0 and `valid_out` = 0.
  - All pointers and counts = 0.
  - Storage RAM is not reset.
- Reset asserted mid-operation discards all contents immediately; no output glitches back to pre-reset data.

## Timing
- Pop to data: 1 cycle. A pop sampled at edge N gives `fifo_out`/`valid_out` valid after edge N until edge N+1.
- Push to status: after the write edge, `empty` deasserts and `almost_full`/`full` update in the same cycle.
- Pop to status: same-cycle update after the pop edge.
- Back-to-back pops on any channels, every cycle: full throughput.
- The arbiter must not pop a channel whose `empty` bit is high. It must not push a channel whose `almost_full` bit is high. The `AF_THRESH` margin covers the arbiter's one-cycle pipeline.

## Configuration
- `FIFO_BANK_ERR_EN` defined:
  - `error[i]` sets on push to a full channel without a same-cycle pop.
  - `error[i]` sets on pop from an empty channel.
  - `error[0]` also sets on any multi-hot `push` or `pop`.
  - Bits stay set until reset.
- `FIFO_BANK_ERR_EN` undefined:
  - `error` port and its logic are absent.
  - Faulting requests are silently ignored as described in Operation.

## Structure
- Package `fifo_bank_pkg`:
  - `WORD_W` = 12 and `N_CH` = 4.
  - Word fields: `dest` = bits [11:10], `payload` = bits [9:0].
  - Function `lowest_onehot(logic [3:0])`.
- Sub-module `fifo_unit`: one channel, holding storage, pointers, count and flags.
  - Four instances.
  - Top level holds the one-hot decode, the pop mux and the output register.

## Test plan
- Reset, then push 12'h096 ×4 into channel 0 → `empty` = 4'b1110. Pop 4 times → `fifo_out` = 12'h096 each cycle with `valid_out` high; then `empty[0]` = 1.
- Push 6 words into channel 2 → `almost_full` = 4'b0100. Push 2 more → `full[2]` = 1. A ninth push is dropped, and `error[2]` = 1 if `FIFO_BANK_ERR_EN`.
- Fill channel 1 to 8, then push 12'h8F0 and pop together → count stays 8 and `fifo_out` = first word. After 8 more pops the last word is 12'h8F0, which verifies wrap-around.
- Pop channel 3 while empty → `valid_out` = 0 and count stays 0. Push and pop channel 3 together while empty → count 1, `valid_out` = 0.
- `pop` = 4'b0110 with channels 1 and 2 non-empty → only channel 1 is popped; with `FIFO_BANK_ERR_EN`, `error[0]` = 1.
- Assert `reset` low mid-stream with channels partly full → `empty` = 4'b1111, `valid_out` = 0 and `fifo_out` = 0, asynchronously before the next edge.

Source files
------------

// File: rtl/fifo_bank_pkg.sv
// fifo_bank_pkg: shared constants, word layout and one-hot helpers for the
// four-channel FIFO bank.
//   WORD_W        - width of a stored word
//   N_CH          - number of channels
//   word_t        - word layout: dest [11:10], payload [9:0]
//   lowest_onehot - keeps only the lowest set bit of a request vector
//   is_multi_hot  - true when more than one request bit is set
package fifo_bank_pkg;

    localparam int unsigned WORD_W = 12;
    localparam int unsigned N_CH   = 4;

    typedef struct packed {
        logic [1:0] dest;
        logic [9:0] payload;
    } word_t;

    // Two's-complement trick: v & -v isolates the lowest set bit.
    function automatic logic [N_CH-1:0] lowest_onehot(input logic [N_CH-1:0] v);
        return v & (~v + {{(N_CH-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic is_multi_hot(input logic [N_CH-1:0] v);
        return (v & (v - {{(N_CH-1){1'b0}}, 1'b1})) != '0;
    endfunction

endpackage

// File: rtl/fifo_unit.sv
// fifo_unit: one FIFO channel - circular storage, pointers, occupancy count
// and status flags.
// Optional feature macro: FIFO_BANK_ERR_EN adds the sticky err_o flag.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, data_i  - decoded write strobe and write word
//   pop_i           - decoded read strobe
//   head_o          - word at the read pointer (valid when not empty)
//   pop_ok_o        - this cycle's pop is accepted
//   empty_o, almost_full_o, full_o - status derived from the count
//   err_o           - sticky fault flag (FIFO_BANK_ERR_EN only)
module fifo_unit
    import fifo_bank_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  word_t data_i,
    input  logic  pop_i,
    output word_t head_o,
    output logic  pop_ok_o,
    output logic  empty_o,
    output logic  almost_full_o,
`ifdef FIFO_BANK_ERR_EN
    output logic  full_o,
    output logic  err_o
`else
    output logic  full_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    word_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok, pop_ok;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CW'(DEPTH));
    assign almost_full_o = (count_q >= CW'(AF_THRESH));

    // A full channel still takes a push when it is popped in the same cycle.
    assign pop_ok   = pop_i && !empty_o;
    assign push_ok  = push_i && (!full_o || pop_ok);
    assign pop_ok_o = pop_ok;
    assign head_o   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

`ifdef FIFO_BANK_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((push_i && full_o && !pop_ok) || (pop_i && empty_o)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: rtl/fifo_bank.sv
// fifo_bank: four-channel 12-bit FIFO bank with one-hot push/pop strobes.
// Optional feature macro: FIFO_BANK_ERR_EN adds the sticky error_o flags.
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   push_i, data_in_i - one-hot write strobe and shared write word
//   pop_i            - one-hot read strobe
//   fifo_out_o       - registered popped word
//   valid_out_o      - fifo_out_o holds a word popped in the previous cycle
//   empty_o, almost_full_o, full_o - per-channel status
//   error_o          - per-channel sticky faults (FIFO_BANK_ERR_EN only)
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_CH-1:0]   push_i,
    input  logic [WORD_W-1:0] data_in_i,
    input  logic [N_CH-1:0]   pop_i,
    output logic [WORD_W-1:0] fifo_out_o,
    output logic              valid_out_o,
    output logic [N_CH-1:0]   empty_o,
    output logic [N_CH-1:0]   almost_full_o,
`ifdef FIFO_BANK_ERR_EN
    output logic [N_CH-1:0]   full_o,
    output logic [N_CH-1:0]   error_o
`else
    output logic [N_CH-1:0]   full_o
`endif
);

    logic [N_CH-1:0]   push_sel, pop_sel, pop_ok;
    word_t             head [N_CH];
    word_t             head_mux;
    logic [WORD_W-1:0] fifo_out_q;
    logic              valid_out_q;

    // Multi-hot requests serve only the lowest channel.
    assign push_sel = lowest_onehot(push_i);
    assign pop_sel  = lowest_onehot(pop_i);

`ifdef FIFO_BANK_ERR_EN
    logic [N_CH-1:0] unit_err;
`endif

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        fifo_unit #(
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo_unit (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .push_i        (push_sel[ch]),
            .data_i        (word_t'(data_in_i)),
            .pop_i         (pop_sel[ch]),
            .head_o        (head[ch]),
            .pop_ok_o      (pop_ok[ch]),
            .empty_o       (empty_o[ch]),
            .almost_full_o (almost_full_o[ch]),
`ifdef FIFO_BANK_ERR_EN
            .full_o        (full_o[ch]),
            .err_o         (unit_err[ch])
`else
            .full_o        (full_o[ch])
`endif
        );
    end

    // pop_ok is at most one-hot, so an OR-mux is sufficient.
    always_comb begin
        head_mux = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (pop_ok[ch]) head_mux = head_mux | head[ch];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= |pop_ok;
            if (|pop_ok) fifo_out_q <= head_mux;
        end
    end

    assign fifo_out_o  = fifo_out_q;
    assign valid_out_o = valid_out_q;

`ifdef FIFO_BANK_ERR_EN
    logic multi_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            multi_err_q <= 1'b0;
        end else if (is_multi_hot(push_i) || is_multi_hot(pop_i)) begin
            multi_err_q <= 1'b1;
        end
    end

    assign error_o = unit_err | {{(N_CH-1){1'b0}}, multi_err_q};
`endif

endmodule
